rsa_modexp: RTL and testbench



---
 rtl/rsa_modexp.sv | 103 ++++++++++
 tb/tb_rsa_modexp.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp.sv
// rtl/rsa_modexp.sv - sequential right-to-left square-and-multiply modular exponentiation
// Optional macro RSA_MODEXP_EARLY_EXIT_EN: leave CALC as soon as the remaining exponent is zero.
module rsa_modexp #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in_n,
    input  logic [2*WIDTH-1:0] in_key,
    input  logic [2*WIDTH-1:0] in_msg,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] out_data
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(W2 + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [W2-1:0]   n_q, n_d;
    logic [W2-1:0]   exp_q, exp_d;
    logic [W2-1:0]   base_q, base_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]   exp_shift;

    // A zero modulus yields zero rather than dividing by zero.
    function automatic logic [W2-1:0] mul_mod(input logic [W2-1:0] a,
                                              input logic [W2-1:0] b,
                                              input logic [W2-1:0] m);
        logic [2*W2-1:0] p;
        p = {{W2{1'b0}}, a} * {{W2{1'b0}}, b};
        if (m == '0)
            return '0;
        return W2'(p % {{W2{1'b0}}, m});
    endfunction

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        exp_d     = exp_q;
        base_d    = base_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        exp_shift = exp_q >> 1;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = CALC;
                    n_d     = in_n;
                    exp_d   = in_key;
                    base_d  = (in_n == '0) ? '0 : in_msg % in_n;
                    acc_d   = W2'(in_n > W2'(1));
                    cnt_d   = '0;
                end
            end
            CALC: begin
                if (exp_q[0])
                    acc_d = mul_mod(acc_q, base_q, n_q);
                base_d = mul_mod(base_q, base_q, n_q);
                exp_d  = exp_shift;
                cnt_d  = cnt_q + CW'(1);
`ifdef RSA_MODEXP_EARLY_EXIT_EN
                if (cnt_q == CW'(W2 - 1) || exp_shift == '0)
                    state_d = DONE;
`else
                if (cnt_q == CW'(W2 - 1))
                    state_d = DONE;
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = acc_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            exp_q   <= '0;
            base_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            exp_q   <= exp_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_rsa_modexp.sv
// tb/tb_rsa_modexp.sv - scoreboard bench for rsa_modexp at WIDTH=4
module tb_rsa_modexp;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_n = '0, in_key = '0, in_msg = '0;
    logic       out_valid;
    logic [7:0] out_data;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int ops_done = 0;

    typedef struct {
        logic [7:0] data;
        int         lat;
    } exp_t;
    exp_t sb[$];

    rsa_modexp #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_n(in_n), .in_key(in_key), .in_msg(in_msg),
        .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (out_valid) pulses++;

    // Reference by repeated multiplication, independent of the bit-serial algorithm.
    function automatic logic [7:0] ref_modexp(input int n, input int key, input int msg);
        int r;
        if (n == 0) return 8'd0;
        r = 1 % n;
        for (int i = 0; i < key; i++) r = (r * (msg % n)) % n;
        return 8'(r);
    endfunction

    function automatic int ref_lat(input int key);
`ifdef RSA_MODEXP_EARLY_EXIT_EN
        int bl;
        bl = 0;
        for (int i = 0; i < 8; i++) if ((key >> i) & 1) bl = i + 1;
        return (bl < 1 ? 1 : bl) + 1;
`else
        return 9;
`endif
    endfunction

    // Caller sits at a negedge; returns at the negedge right after the DONE cycle.
    task automatic run_op(input string name, input logic [7:0] n, input logic [7:0] key,
                          input logic [7:0] msg, input logic [7:0] want, input bit inject_busy);
        exp_t e;
        int   lat;
        bit   zero_ok;
        e.data = want;
        e.lat  = ref_lat(key);
        sb.push_back(e);
        in_n = n; in_key = key; in_msg = msg; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_n = 8'hAA; in_key = 8'h55; in_msg = 8'hC3;
        lat = 1;
        zero_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (out_data !== 8'd0) zero_ok = 1'b0;
            if (in_ready !== 1'b0) zero_ok = 1'b0;
            if (inject_busy && lat == 3) begin
                in_n = 8'd33; in_key = 8'd3; in_msg = 8'd2; in_valid = 1'b1;
            end
            if (inject_busy && lat == 4) in_valid = 1'b0;
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s timeout: no out_valid within %0d cycles", name, lat);
        end else begin
            checks++;
            if (out_data !== e.data) begin
                errors++;
                $display("FAIL %s data: got %0d expected %0d", name, out_data, e.data);
            end
            checks++;
            if (lat != e.lat) begin
                errors++;
                $display("FAIL %s latency: got cycle %0d expected cycle %0d", name, lat, e.lat);
            end
            ops_done++;
        end
        checks++;
        if (!zero_ok) begin
            errors++;
            $display("FAIL %s idle outputs: out_data nonzero or in_ready high while busy (got 0 expected 1)", name);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s post_done: got valid=%b data=%0d ready=%b expected 0/0/1",
                     name, out_valid, out_data, in_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b valid=%b data=%0d expected 1/0/0",
                     in_ready, out_valid, out_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_encrypt_decrypt;
        run_op("encrypt", 8'd33, 8'd7, 8'd4, 8'd16, 1'b0);
        run_op("decrypt", 8'd33, 8'd3, 8'd16, 8'd4, 1'b0);
    endtask

    task automatic test_edges;
        run_op("key0", 8'd33, 8'd0, 8'd5, 8'd1, 1'b0);
        run_op("n1", 8'd1, 8'd5, 8'd9, 8'd0, 1'b0);
        run_op("n0", 8'd0, 8'd7, 8'd4, 8'd0, 1'b0);
        run_op("msg_ge_n", 8'd33, 8'd1, 8'd40, 8'd7, 1'b0);
        run_op("full_exp", 8'd251, 8'd255, 8'd250, ref_modexp(251, 255, 250), 1'b0);
    endtask

    task automatic test_back_to_back;
        int p0;
        p0 = pulses;
        run_op("busy_first", 8'd33, 8'd7, 8'd4, 8'd16, 1'b1);
        run_op("busy_next", 8'd35, 8'd5, 8'd3, ref_modexp(35, 5, 3), 1'b0);
        checks++;
        if (pulses - p0 != 2) begin
            errors++;
            $display("FAIL busy_pulses: got %0d out_valid pulses expected 2", pulses - p0);
        end
    endtask

    task automatic test_reset_mid_op;
        int  p0;
        bit  bad;
        p0 = pulses;
        bad = 1'b0;
        in_n = 8'd33; in_key = 8'd200; in_msg = 8'd4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0) bad = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bad || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_op state: got ready=%b bad=%b expected ready=1 bad=0", in_ready, bad);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (pulses != p0) begin
            errors++;
            $display("FAIL reset_mid_op discard: got %0d pulses expected 0", pulses - p0);
        end
        run_op("after_reset", 8'd33, 8'd7, 8'd4, 8'd16, 1'b0);
    endtask

    task automatic test_random;
        logic [7:0] n, k, m;
        for (int i = 0; i < 8; i++) begin
            n = 8'($urandom_range(0, 255));
            k = 8'($urandom_range(0, 255));
            m = 8'($urandom_range(0, 255));
            run_op("random", n, k, m, ref_modexp(n, k, m), 1'b0);
        end
    endtask

    initial begin
        test_reset;
        test_encrypt_decrypt;
        test_edges;
        test_back_to_back;
        test_reset_mid_op;
        test_random;
        checks++;
        if (pulses != ops_done) begin
            errors++;
            $display("FAIL pulse_total: got %0d out_valid pulses expected %0d", pulses, ops_done);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
